// File: rtl/bus_load_unit_if.sv
// Bus/handshake bundle for the bus load unit: common bus, load/inr/clr
// strobes, memory write port and the architectural register outputs.
interface bus_load_unit_if #(
    parameter int WIDTH = 16
);
    logic [WIDTH-1:0]   bus_content;
    logic [2:0]         load_select;
    logic               load_en;
    logic [5:0]         inr;
    logic [5:0]         clr;
    logic               mem_ready;

    logic [WIDTH-5:0]   AR;
    logic [WIDTH-5:0]   PC;
    logic [WIDTH-1:0]   DR;
    logic [WIDTH-1:0]   AC;
    logic [WIDTH-1:0]   IR;
    logic [WIDTH-1:0]   TR;
    logic               mem_we;
    logic [WIDTH-5:0]   mem_addr;
    logic [WIDTH-1:0]   mem_wdata;
    logic               busy;

    // Stimulus side: drives bus/strobes, observes registers and memory port
    modport master (
        output bus_content, load_select, load_en, inr, clr, mem_ready,
        input  AR, PC, DR, AC, IR, TR, mem_we, mem_addr, mem_wdata, busy
    );

    // Unit side
    modport slave (
        input  bus_content, load_select, load_en, inr, clr, mem_ready,
        output AR, PC, DR, AC, IR, TR, mem_we, mem_addr, mem_wdata, busy
    );
endinterface

// File: rtl/bus_load_unit.sv
// Bus load unit: six architectural registers loaded from a common bus with
// per-register clear/load/increment priority, plus a two-state memory write
// FSM that captures the pre-update AR and bus value and holds them until
// memory acknowledges with mem_ready.
module bus_load_unit #(
    parameter int WIDTH = 16
) (
    input  logic          clk,
    input  logic          rst,
    bus_load_unit_if.slave bus
);
    localparam int AW = WIDTH - 4;

    typedef enum logic {IDLE, WRITE} state_t;

    logic [AW-1:0]    ar_q, ar_d;
    logic [AW-1:0]    pc_q, pc_d;
    logic [WIDTH-1:0] dr_q, dr_d;
    logic [WIDTH-1:0] ac_q, ac_d;
    logic [WIDTH-1:0] ir_q, ir_d;
    logic [WIDTH-1:0] tr_q, tr_d;

    state_t           state_q;
    logic             mem_we_q;
    logic [AW-1:0]    mem_addr_q;
    logic [WIDTH-1:0] mem_wdata_q;
    logic             busy_q;

    // One-hot destination decode; bit 0 is "none", bit 7 is the memory write
    logic [7:0] ld;
    assign ld = bus.load_en ? (8'b1 << bus.load_select) : 8'b0;

    // IR has no increment/clear strobe, and code 0 loads nothing
    logic unused_strobes;
    assign unused_strobes = bus.inr[4] ^ bus.clr[4] ^ ld[0];

    function automatic logic [AW-1:0] upd_addr(input logic [AW-1:0] cur,
                                               input logic c, input logic l,
                                               input logic i,
                                               input logic [AW-1:0] val);
        if (c)      return '0;
        else if (l) return val;
        else if (i) return cur + AW'(1);
        else        return cur;
    endfunction

    function automatic logic [WIDTH-1:0] upd_data(input logic [WIDTH-1:0] cur,
                                                  input logic c, input logic l,
                                                  input logic i,
                                                  input logic [WIDTH-1:0] val);
        if (c)      return '0;
        else if (l) return val;
        else if (i) return cur + WIDTH'(1);
        else        return cur;
    endfunction

    // Next-state for every register: clear beats load beats increment
    always_comb begin
        ar_d = upd_addr(ar_q, bus.clr[0], ld[1], bus.inr[0], bus.bus_content[AW-1:0]);
        pc_d = upd_addr(pc_q, bus.clr[1], ld[2], bus.inr[1], bus.bus_content[AW-1:0]);
        dr_d = upd_data(dr_q, bus.clr[2], ld[3], bus.inr[2], bus.bus_content);
        ac_d = upd_data(ac_q, bus.clr[3], ld[4], bus.inr[3], bus.bus_content);
        ir_d = ld[5] ? bus.bus_content : ir_q;
        tr_d = upd_data(tr_q, bus.clr[5], ld[6], bus.inr[5], bus.bus_content);
    end

    // Architectural registers; they keep updating while a write is pending
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ar_q <= '0;
            pc_q <= '0;
            dr_q <= '0;
            ac_q <= '0;
            ir_q <= '0;
            tr_q <= '0;
        end else begin
            ar_q <= ar_d;
            pc_q <= pc_d;
            dr_q <= dr_d;
            ac_q <= ac_d;
            ir_q <= ir_d;
            tr_q <= tr_d;
        end
    end

    // Memory write FSM; captures ar_q (pre-update) so a same-cycle AR
    // inc/clr cannot leak into the write address. Requests in WRITE drop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (ld[7]) begin
                        mem_addr_q  <= ar_q;
                        mem_wdata_q <= bus.bus_content;
                        mem_we_q    <= 1'b1;
                        busy_q      <= 1'b1;
                        state_q     <= WRITE;
                    end
                end
                WRITE: begin
                    if (bus.mem_ready) begin
                        mem_we_q <= 1'b0;
                        busy_q   <= 1'b0;
                        state_q  <= IDLE;
                    end
                end
                default: begin
                    mem_we_q <= 1'b0;
                    busy_q   <= 1'b0;
                    state_q  <= IDLE;
                end
            endcase
        end
    end

    assign bus.AR        = ar_q;
    assign bus.PC        = pc_q;
    assign bus.DR        = dr_q;
    assign bus.AC        = ac_q;
    assign bus.IR        = ir_q;
    assign bus.TR        = tr_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.busy      = busy_q;
endmodule

// File: tb/tb_bus_load_unit.sv
// Directed bench for bus_load_unit: each cycle's expected outputs come from
// a small behavioural model, are queued when stimulus is driven and popped
// after the clock edge, alongside hard-coded scenario checks.
module tb_bus_load_unit;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    bus_load_unit_if #(.WIDTH(16)) bif ();

    bus_load_unit #(.WIDTH(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bif)
    );

    typedef struct {
        logic [11:0] ar, pc;
        logic [15:0] dr, ac, ir, tr;
        logic        we;
        logic [11:0] maddr;
        logic [15:0] wdata;
        logic        busy;
    } snap_t;

    snap_t q[$];
    snap_t m;
    int    ncmp = 0;
    int    nerr = 0;
    int    weh;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic snap_t zero_snap();
        snap_t s;
        s.ar = '0; s.pc = '0; s.dr = '0; s.ac = '0; s.ir = '0; s.tr = '0;
        s.we = 1'b0; s.maddr = '0; s.wdata = '0; s.busy = 1'b0;
        return s;
    endfunction

    // Reference behaviour written as an indexed register file with masks
    function automatic snap_t model_next(input snap_t s, input logic [15:0] bv,
                                         input logic [2:0] sel, input logic en,
                                         input logic [5:0] inc, input logic [5:0] cl,
                                         input logic rdy);
        logic [15:0] r[1:6];
        logic [15:0] mask;
        snap_t n;
        r[1] = {4'h0, s.ar}; r[2] = {4'h0, s.pc};
        r[3] = s.dr; r[4] = s.ac; r[5] = s.ir; r[6] = s.tr;
        for (int k = 1; k <= 6; k++) begin
            mask = (k <= 2) ? 16'h0FFF : 16'hFFFF;
            if (k != 5 && cl[k-1])           r[k] = 16'h0000;
            else if (en && sel == 3'(k))     r[k] = bv & mask;
            else if (k != 5 && inc[k-1])     r[k] = (r[k] + 16'd1) & mask;
        end
        n = s;
        n.ar = r[1][11:0]; n.pc = r[2][11:0];
        n.dr = r[3]; n.ac = r[4]; n.ir = r[5]; n.tr = r[6];
        if (!s.busy) begin
            if (en && sel == 3'd7) begin
                n.we = 1'b1; n.busy = 1'b1; n.maddr = s.ar; n.wdata = bv;
            end
        end else if (rdy) begin
            n.we = 1'b0; n.busy = 1'b0;
        end
        return n;
    endfunction

    task automatic cmp_snap(input string pfx, input snap_t e);
        chk({pfx, ".AR"},        {20'h0, bif.AR},       {20'h0, e.ar});
        chk({pfx, ".PC"},        {20'h0, bif.PC},       {20'h0, e.pc});
        chk({pfx, ".DR"},        {16'h0, bif.DR},       {16'h0, e.dr});
        chk({pfx, ".AC"},        {16'h0, bif.AC},       {16'h0, e.ac});
        chk({pfx, ".IR"},        {16'h0, bif.IR},       {16'h0, e.ir});
        chk({pfx, ".TR"},        {16'h0, bif.TR},       {16'h0, e.tr});
        chk({pfx, ".mem_we"},    {31'h0, bif.mem_we},   {31'h0, e.we});
        chk({pfx, ".mem_addr"},  {20'h0, bif.mem_addr}, {20'h0, e.maddr});
        chk({pfx, ".mem_wdata"}, {16'h0, bif.mem_wdata},{16'h0, e.wdata});
        chk({pfx, ".busy"},      {31'h0, bif.busy},     {31'h0, e.busy});
    endtask

    // Drive one cycle, queue the predicted outputs, then pop and compare
    task automatic cyc(input logic [15:0] bv, input logic [2:0] sel, input logic en,
                       input logic [5:0] inc, input logic [5:0] cl, input logic rdy);
        snap_t e;
        bif.bus_content = bv; bif.load_select = sel; bif.load_en = en;
        bif.inr = inc; bif.clr = cl; bif.mem_ready = rdy;
        q.push_back(model_next(m, bv, sel, en, inc, cl, rdy));
        @(posedge clk);
        #1;
        if (q.size() == 0) begin
            ncmp++; nerr++;
            $error("FAIL scoreboard_empty observed=0 expected=1");
        end else begin
            e = q.pop_front();
            cmp_snap("cyc", e);
            m = e;
        end
    endtask

    initial begin
        bif.bus_content = '0; bif.load_select = '0; bif.load_en = 1'b0;
        bif.inr = '0; bif.clr = '0; bif.mem_ready = 1'b0;
        m = zero_snap();
        @(posedge clk);
        #1;
        cmp_snap("reset", zero_snap());
        @(negedge clk);
        rst = 1'b0;

        // Bus load into AR keeps only the low 12 bits
        cyc(16'hABCD, 3'd1, 1'b1, 6'b0, 6'b0, 1'b0);
        chk("scn_ar_load", {20'h0, bif.AR}, 32'h0BCD);
        // Wraparound increments
        cyc(16'hFFFF, 3'd4, 1'b1, 6'b0, 6'b0, 1'b0);
        cyc(16'hFFFF, 3'd2, 1'b1, 6'b0, 6'b0, 1'b0);
        chk("scn_pc_trunc", {20'h0, bif.PC}, 32'h0FFF);
        cyc(16'h0000, 3'd0, 1'b0, 6'b001010, 6'b0, 1'b0);
        chk("scn_ac_wrap", {16'h0, bif.AC}, 32'h0000);
        chk("scn_pc_wrap", {20'h0, bif.PC}, 32'h0000);
        // Clear beats load beats increment on DR
        cyc(16'h00FF, 3'd3, 1'b1, 6'b0, 6'b0, 1'b0);
        cyc(16'h1234, 3'd3, 1'b1, 6'b000100, 6'b000100, 1'b0);
        chk("scn_dr_clr_prio", {16'h0, bif.DR}, 32'h0000);
        // Load beats increment
        cyc(16'h4321, 3'd6, 1'b1, 6'b100000, 6'b0, 1'b0);
        chk("scn_tr_load_prio", {16'h0, bif.TR}, 32'h4321);
        // IR ignores inr/clr bit 4
        cyc(16'hC0DE, 3'd5, 1'b1, 6'b0, 6'b0, 1'b0);
        cyc(16'h0000, 3'd0, 1'b0, 6'b010000, 6'b0, 1'b0);
        cyc(16'h0000, 3'd0, 1'b0, 6'b0, 6'b010000, 1'b0);
        chk("scn_ir_strobes", {16'h0, bif.IR}, 32'hC0DE);
        // No load with load_en low or select 0; mem_ready ignored in IDLE
        cyc(16'h5555, 3'd3, 1'b0, 6'b0, 6'b0, 1'b1);
        cyc(16'h5555, 3'd0, 1'b1, 6'b0, 6'b0, 1'b1);
        chk("scn_no_load_dr", {16'h0, bif.DR}, 32'h0000);
        chk("scn_idle_ready", {31'h0, bif.busy}, 32'h0);

        // Memory write with AR increment, a dropped request and 3 wait cycles
        cyc(16'h0055, 3'd1, 1'b1, 6'b0, 6'b0, 1'b0);
        weh = 0;
        cyc(16'h7E7E, 3'd7, 1'b1, 6'b000001, 6'b0, 1'b0);
        if (bif.mem_we) weh++;
        chk("scn_wr_addr", {20'h0, bif.mem_addr}, 32'h0055);
        chk("scn_ar_inc", {20'h0, bif.AR}, 32'h0056);
        cyc(16'h1111, 3'd7, 1'b1, 6'b0, 6'b0, 1'b0);
        if (bif.mem_we) weh++;
        chk("scn_drop_data", {16'h0, bif.mem_wdata}, 32'h7E7E);
        cyc(16'h0000, 3'd0, 1'b0, 6'b0, 6'b0, 1'b0);
        if (bif.mem_we) weh++;
        cyc(16'hAAAA, 3'd4, 1'b1, 6'b0, 6'b0, 1'b0);
        if (bif.mem_we) weh++;
        chk("scn_ac_during_write", {16'h0, bif.AC}, 32'hAAAA);
        cyc(16'h0000, 3'd0, 1'b0, 6'b0, 6'b0, 1'b1);
        if (bif.mem_we) weh++;
        chk("scn_we_cycles", weh, 32'd4);
        chk("scn_busy_fall", {31'h0, bif.busy}, 32'h0);

        // Back-to-back request right after busy falls is accepted
        cyc(16'h2222, 3'd7, 1'b1, 6'b0, 6'b000001, 1'b1);
        chk("scn_b2b_busy", {31'h0, bif.busy}, 32'h1);
        chk("scn_b2b_addr", {20'h0, bif.mem_addr}, 32'h0056);
        cyc(16'h0000, 3'd0, 1'b0, 6'b0, 6'b0, 1'b1);

        // Reset between edges aborts a pending write
        cyc(16'h3333, 3'd7, 1'b1, 6'b0, 6'b0, 1'b0);
        #2 rst = 1'b1;
        #1;
        m = zero_snap();
        q.delete();
        cmp_snap("async_rst", m);
        #2 rst = 1'b0;
        cyc(16'h0000, 3'd0, 1'b0, 6'b0, 6'b0, 1'b1);
        chk("scn_post_rst_we", {31'h0, bif.mem_we}, 32'h0);
        cyc(16'h0ABC, 3'd1, 1'b1, 6'b0, 6'b0, 1'b0);
        chk("scn_post_rst_load", {20'h0, bif.AR}, 32'h0ABC);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

    // Hard stop in case the main sequence never completes
    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
